// File: rtl/gearbox_128_132.sv
// rtl/gearbox_128_132.sv - receive gearbox packing 128-bit PHY words into 132-bit link words.
// Optional alignment checker enabled by defining GBX_ALIGN_CHK_EN (adds o_align_err).
module gearbox_128_132 (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_vld,
    input  logic [127:0] i_data,
    input  logic         i_sync,
    output logic         o_vld,
    output logic [131:0] o_data,
    output logic         o_sof,
`ifdef GBX_ALIGN_CHK_EN
    output logic         o_align_err,
`endif
    output logic         o_locked
);

    localparam int DIN_W  = 128;
    localparam int DOUT_W = 132;
    localparam int GRP_IN = 33;

    logic [7:0]   fill;
    logic [5:0]   phase;
    logic [127:0] res;

    logic         accept;
    logic         emit;
    logic [255:0] cat;
    logic [7:0]   fill_nxt;
    logic [5:0]   phase_nxt;
    logic [127:0] res_nxt;

    // res is kept zero above fill, so OR-ing the shifted input word forms the
    // concatenation {i_data, res[fill-1:0]} without a separate mask.
    always_comb begin
        accept    = i_vld && (o_locked || i_sync);
        cat       = ({{(256-DIN_W){1'b0}}, i_data} << fill) | {128'b0, res};
        emit      = accept && !i_sync && (fill >= 8'd4);
        fill_nxt  = fill;
        phase_nxt = phase;
        res_nxt   = res;
        if (accept) begin
            if (i_sync) begin
                fill_nxt  = 8'd128;
                res_nxt   = i_data;
                phase_nxt = 6'd1;
            end else begin
                phase_nxt = (phase == 6'(GRP_IN - 1)) ? 6'd0 : phase + 6'd1;
                if (emit) begin
                    // fill + 128 - 132
                    fill_nxt = fill - 8'd4;
                    res_nxt  = {4'b0, cat[255:DOUT_W]};
                end else begin
                    // only reachable with fill == 0
                    fill_nxt = 8'd128;
                    res_nxt  = cat[127:0];
                end
            end
        end
    end

`ifdef GBX_ALIGN_CHK_EN
    logic align_bad;
    always_comb begin
        align_bad = 1'b0;
        if (accept && i_sync && phase != 6'd0)
            align_bad = 1'b1;
        if (accept && !i_sync && phase == 6'(GRP_IN - 1) && fill_nxt != 8'd0)
            align_bad = 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst)
            o_align_err <= 1'b0;
        else if (align_bad)
            o_align_err <= 1'b1;
    end
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fill     <= 8'd0;
            phase    <= 6'd0;
            res      <= '0;
            o_vld    <= 1'b0;
            o_data   <= '0;
            o_sof    <= 1'b0;
            o_locked <= 1'b0;
        end else begin
            fill   <= fill_nxt;
            phase  <= phase_nxt;
            res    <= res_nxt;
            o_vld  <= emit;
            o_sof  <= emit && (phase == 6'd1);
            if (emit)
                o_data <= cat[DOUT_W-1:0];
            if (accept && i_sync)
                o_locked <= 1'b1;
        end
    end

endmodule

// File: doc/gearbox_128_132.md
Name: gearbox_128_132

Overview:
- Receive-direction gearbox: packs 128-bit PHY-side words back into 132-bit link-layer words.
- It is the inverse of the transmit-path 132->128 conversion: every 33 input words yield exactly 32 output words.
- Sits in the PHY receive clock domain, upstream of the async FIFO that carries 132-bit words to the link layer.
- Single clock; no output backpressure, since the output rate is always lower than the input rate.

Parameters:
- DIN_W, 128, input word width; fixed, other values unsupported.
- DOUT_W, 132, output word width; fixed, other values unsupported.
- GRP_IN, 33, input words per alignment group; fixed.

Ports:
- i_clk  input  1  receive clock; all logic on rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_vld  input  1  i_data valid this cycle.
- i_data  input  128  PHY word; bit 0 is the earliest bit on the line.
- i_sync  input  1  qualified by i_vld; marks this word as word 0 of a 33-word group.
- o_vld  output  1  o_data valid, single-cycle pulse per word.
- o_data  output  132  link word; bit 0 is the earliest bit.
- o_sof  output  1  with o_vld; marks output word 0 of a 32-word group.
- o_locked  output  1  high once an i_sync has been accepted since reset.

Behaviour:
- Reset (i_rst=1 at the clock edge):
  - o_vld=0, o_data=0, o_sof=0, o_locked=0.
  - Fill level=0, input phase counter=0, residue buffer cleared.
  - Reset mid-group discards all held bits.
- State:
  - fill: bits held, values 0..128 in steps of 4, 8-bit register.
  - phase: input index within the group, 0..32, 6-bit register.
  - res: 128-bit residue buffer; the valid bits are res[fill-1:0].
- Before lock (o_locked=0): i_vld words without i_sync are dropped; no output.
- Accepted word (i_vld=1, locked or i_sync=1):
  - Form cat = {i_data, res[fill-1:0]}, with total = fill+128.
  - If total >= 132: next cycle o_vld=1 and o_data=cat[131:0]; then fill <= total-132 and res <= cat >> 132.
  - Otherwise fill <= total, no output.
  - phase <= (phase==32) ? 0 : phase+1.
  - After word 32, fill is exactly 0.
- i_sync with i_vld:
  - Word is treated as phase 0: existing residue is discarded, fill <= 128, res <= i_data, phase <= 1.
  - o_locked <= 1.
  - An i_sync at phase 0 with fill 0 is a normal group start.
- Latency: o_vld is registered and asserts exactly one cycle after the i_vld that completes a word.
  - Output k (0..31) of a group follows input k+1.
  - Input 0 never produces output.
- o_sof=1 together with the o_vld produced by input phase 1.
- i_vld=0 cycles: all state holds; o_vld=0 the next cycle; o_data holds its last value.
- At most one output per cycle; no overflow is possible because fill is at most 128.
- i_sync without i_vld is ignored.

Optional Feature:
- Macro GBX_ALIGN_CHK_EN.
- When defined:
  - Adds output o_align_err (1 bit, reset 0).
  - Set sticky when i_sync arrives with phase != 0, or when phase wraps 32->0 with fill != 0.
  - Cleared only by i_rst.
  - Realignment on i_sync still occurs.
- When undefined: port and logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset, then 33 words with i_sync on word 0 and i_data = {4{32'hA000_0000 + n}} for n=0..32 -> 32 o_vld pulses:
  - first one cycle after word 1, with o_sof=1 and o_data = {w1[3:0], w0[127:0]};
  - last o_data = {w32[127:0], w31[127:124]};
  - fill=0 and phase=0 afterwards.
- Words sent before any i_sync, then an i_sync group -> no o_vld until input 1 of the synced group; o_locked rises the cycle after the i_sync.
- Same 33-word group with random i_vld gaps (about 50% duty) -> identical o_data sequence to the gapless run; o_vld never asserts on a gap-following cycle without a completing input.
- i_sync reissued at phase 10 -> residue dropped; next output = {new w1[3:0], new w0}; o_align_err=1 if GBX_ALIGN_CHK_EN is defined.
- i_rst asserted at phase 17 for one cycle -> all outputs 0 the next cycle, o_locked=0; recovery after a new i_sync matches the first scenario.
- Two back-to-back full groups (66 words, i_sync only on word 0 and word 33) -> 64 outputs; o_sof on outputs 0 and 32; o_align_err stays 0.
